switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Synchronizes and debounces the eight board slide switches before they reach the combinational switch-to-LED logic. Its `swt_db` output drives that logic's `swt` input directly. Each raw switch bit passes through a two-flop synchronizer and then an independent stability counter. A bit's debounced value changes only after the synchronized input has held the new level for `STABLE_CYCLES` consecutive clocks. Change-pulse and settled status outputs are provided for downstream event logic.

## Interface
- `WIDTH`, 8, number of switch bits.
- `STABLE_CYCLES`, 1000000, consecutive cycles a new synchronized level must persist before it is accepted. This is 10 ms at 100 MHz. Legal range is ≥2.
- `CNT_W`, 20, width of each per-bit counter. Must satisfy 2^CNT_W > STABLE_CYCLES-1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `swt`  in  WIDTH  raw asynchronous switch inputs.
- `swt_db`  out  WIDTH  debounced switch levels; feeds the switch-to-LED stage.
- `swt_changed`  out  WIDTH  one-cycle pulse mask; bit i is high for the single cycle after `swt_db[i]` updates.
- `settled`  out  1  high when every synchronized bit equals its debounced bit, i.e. nothing is pending.

## Operation
- Reset (`rstn`=0 at a rising edge) clears the following:
  - sync stage 1 (`s1`) and stage 2 (`s2`): all 0.
  - all counters: 0.
  - `swt_db`: 0.
  - `swt_changed`: 0.
- Reset value of `settled` is 1, since `s2` and `swt_db` are both 0.
- Synchronizer: `s1` <= `swt`, then `s2` <= `s1`. Only `s2` is used downstream of the synchronizer.
- Per bit i, each cycle, evaluated in this priority order:
  - If `s2[i]` == `swt_db[i]`: set `cnt[i]` <= 0. This is the idle case; any reversion cancels a pending change.
  - Else if `cnt[i]` == `STABLE_CYCLES`-1: set `swt_db[i]` <= `s2[i]`, `cnt[i]` <= 0, and `swt_changed[i]` <= 1.
  - Else: set `cnt[i]` <= `cnt[i]`+1.
- `swt_changed[i]` is 0 in every cycle in which the update branch is not taken. It is a registered pulse, exactly one cycle wide.
- `settled` is combinational: (`s2` == `swt_db`).
- Bits are fully independent. Multiple bits may update in the same cycle, in which case `swt_changed` carries several 1s.
- Counter arithmetic is unsigned, `CNT_W` bits. The counter never exceeds `STABLE_CYCLES`-1, so it never wraps.
- No state machine beyond the per-bit idle/counting condition, which is implied by `s2[i]` != `swt_db[i]`.

## Timing
- Latency: suppose raw `swt[i]` changes before edge E0 and stays constant.
  - `s1` updates at E0 and `s2` at E1.
  - Counter values are 1..`STABLE_CYCLES`-1 at E2..E(`STABLE_CYCLES`).
  - `swt_db[i]` and `swt_changed[i]` update at E(`STABLE_CYCLES`+1). That is `STABLE_CYCLES`+2 edges counting E0.
- `settled` falls after E1 and rises after E(`STABLE_CYCLES`+1).
- Bounce: every cycle in which `s2[i]` returns to `swt_db[i]` zeroes the counter. The latency is then measured from the last transition.
- A raw pulse shorter than `STABLE_CYCLES` cycles never reaches `swt_db`, and no `swt_changed` pulse is produced.
- Reset mid-count discards all pending changes. After release, `swt_db` starts from 0, so an input held high re-qualifies with full latency measured from the first edge with `rstn`=1.
- A reset asserted in the cycle an update would occur takes priority: `swt_db` becomes 0 and `swt_changed` becomes 0.
- The inputs carry no combinational path to any output except `settled`, which depends on `s2` and `swt_db` only.

## Test plan
Benches use `STABLE_CYCLES`=4 and `WIDTH`=8.
- Reset: `rstn`=0 for 3 edges with `swt`=8'hFF. Required: `swt_db`=8'h00, `swt_changed`=8'h00, `settled`=1 throughout reset.
- Step: after reset, `swt`=8'h00→8'h55 before E0 and held. Required:
  - `settled`=0 after E1.
  - `swt_db`=8'h55 and `swt_changed`=8'h55 after E5.
  - `swt_changed`=8'h00 after E6.
  - `settled`=1 after E5.
- Bounce: `swt[0]` toggles 1,0,1,0,1 on successive cycles then holds 1. Required: `swt_db[0]` rises exactly 6 edges after the final 0→1 edge and never earlier; a single pulse on `swt_changed[0]`.
- Glitch: `swt[7]`=1 for 2 cycles, then 0. Required: `swt_db`=8'h00 for the entire run, `swt_changed` never nonzero, and `settled` returns to 1.
- Reset mid-count: `swt`=8'hF0 held, with `rstn`=0 asserted at E3 for one edge. Required: `swt_db` stays 8'h00 through E5, then becomes 8'hF0 six edges after the first edge with `rstn`=1.
- Independent bits: `swt[1]` rises before E0 and `swt[2]` rises before E2. Required: `swt_changed`=8'h02 after E5, 8'h04 after E7, and `swt_db`=8'h06 thereafter.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter for the board slide switches.
// Latency STABLE_CYCLES+2 edges from a raw change to swt_db; no backpressure, free-running.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_db,
  output logic [WIDTH-1:0] swt_changed,
  output logic             settled
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_chg;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= swt;
      r_s2 <= r_s1;
    end
  end

  // Any cycle where the synchronized level matches the accepted level cancels a pending change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rstn) begin
        r_cnt[i] <= '0;
        r_db[i]  <= 1'b0;
        r_chg[i] <= 1'b0;
      end else if (r_s2[i] == r_db[i]) begin
        r_cnt[i] <= '0;
        r_chg[i] <= 1'b0;
      end else if (r_cnt[i] == LP_CNT_MAX) begin
        r_cnt[i] <= '0;
        r_db[i]  <= r_s2[i];
        r_chg[i] <= 1'b1;
      end else begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
        r_chg[i] <= 1'b0;
      end
    end
  end

  assign swt_db      = r_db;
  assign swt_changed = r_chg;
  assign settled     = (r_s2 == r_db);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4; outputs sampled 1 time unit after each rising edge.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] swt;
  logic [7:0] swt_db;
  logic [7:0] swt_changed;
  logic       settled;

  int n_checks = 0;
  int n_errors = 0;

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .swt        (swt),
    .swt_db     (swt_db),
    .swt_changed(swt_changed),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to_zero();
    swt = 8'h00;
    repeat (7) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    swt  = 8'hFF;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (swt_db !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_db edge %0d: got %h want 00", e, swt_db);
      end
      n_checks++;
      if (swt_changed !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_chg edge %0d: got %h want 00", e, swt_changed);
      end
      n_checks++;
      if (settled !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_settled edge %0d: got %b want 1", e, settled);
      end
    end
    rstn = 1'b1;
    flush_to_zero();
  endtask

  task automatic test_step();
    swt = 8'h55;
    tick(); // E0
    tick(); // E1
    n_checks++;
    if (settled !== 1'b0) begin
      n_errors++;
      $display("FAIL step_settled_e1: got %b want 0", settled);
    end
    for (int e = 2; e <= 4; e++) begin
      tick();
      n_checks++;
      if (swt_db !== 8'h00 || swt_changed !== 8'h00) begin
        n_errors++;
        $display("FAIL step_early e%0d: db %h chg %h want 00 00", e, swt_db, swt_changed);
      end
    end
    tick(); // E5
    n_checks++;
    if (swt_db !== 8'h55) begin
      n_errors++;
      $display("FAIL step_db_e5: got %h want 55", swt_db);
    end
    n_checks++;
    if (swt_changed !== 8'h55) begin
      n_errors++;
      $display("FAIL step_chg_e5: got %h want 55", swt_changed);
    end
    n_checks++;
    if (settled !== 1'b1) begin
      n_errors++;
      $display("FAIL step_settled_e5: got %b want 1", settled);
    end
    tick(); // E6
    n_checks++;
    if (swt_changed !== 8'h00 || swt_db !== 8'h55) begin
      n_errors++;
      $display("FAIL step_e6: chg %h db %h want 00 55", swt_changed, swt_db);
    end
    flush_to_zero();
    n_checks++;
    if (swt_db !== 8'h00) begin
      n_errors++;
      $display("FAIL step_return: got %h want 00", swt_db);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int pulses;
    pat    = 5'b10101;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      swt[0] = pat[k];
      tick();
      n_checks++;
      if (swt_db[0] !== 1'b0 || swt_changed[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL bounce_early step %0d: db %b chg %b want 0 0", k, swt_db[0], swt_changed[0]);
      end
    end
    swt[0] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (swt_changed[0] === 1'b1) pulses++;
      n_checks++;
      if (swt_db[0] !== (e >= 5)) begin
        n_errors++;
        $display("FAIL bounce_db e%0d: got %b want %b", e, swt_db[0], (e >= 5));
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL bounce_pulses: got %0d want 1", pulses);
    end
    flush_to_zero();
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    swt = 8'h80;
    tick();
    tick();
    swt = 8'h00;
    for (int e = 0; e < 10; e++) begin
      if (e < 2) begin
        // glitch edges were already clocked above; just keep watching
      end
      tick();
      if (swt_db !== 8'h00 || swt_changed !== 8'h00) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL glitch_outputs: got %0d nonzero cycles want 0", bad);
    end
    n_checks++;
    if (settled !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_settled: got %b want 1", settled);
    end
  endtask

  task automatic test_reset_mid();
    swt = 8'hF0;
    for (int e = 0; e <= 2; e++) tick();
    rstn = 1'b0;
    tick(); // E3
    rstn = 1'b1;
    n_checks++;
    if (swt_db !== 8'h00 || swt_changed !== 8'h00) begin
      n_errors++;
      $display("FAIL rstmid_e3: db %h chg %h want 00 00", swt_db, swt_changed);
    end
    for (int e = 4; e <= 8; e++) begin
      tick();
      n_checks++;
      if (swt_db !== 8'h00) begin
        n_errors++;
        $display("FAIL rstmid_hold e%0d: got %h want 00", e, swt_db);
      end
    end
    tick(); // E9
    n_checks++;
    if (swt_db !== 8'hF0 || swt_changed !== 8'hF0) begin
      n_errors++;
      $display("FAIL rstmid_e9: db %h chg %h want F0 F0", swt_db, swt_changed);
    end
    flush_to_zero();
  endtask

  task automatic test_independent();
    logic [7:0] exp_chg [9];
    logic [7:0] exp_db  [9];
    exp_chg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00};
    exp_db  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h06, 8'h06};
    swt = 8'h02;
    for (int e = 0; e <= 8; e++) begin
      if (e == 2) swt = 8'h06;
      tick();
      n_checks++;
      if (swt_changed !== exp_chg[e] || swt_db !== exp_db[e]) begin
        n_errors++;
        $display("FAIL indep e%0d: chg %h db %h want %h %h", e, swt_changed, swt_db, exp_chg[e], exp_db[e]);
      end
    end
    n_checks++;
    if (settled !== 1'b1) begin
      n_errors++;
      $display("FAIL indep_settled: got %b want 1", settled);
    end
  endtask

  initial begin
    rstn = 1'b0;
    swt  = 8'h00;
    test_reset();
    test_step();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_independent();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
